// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared width and reader state type for the FIFO reader block
package shared_pkg;

    localparam int FIFO_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - two-entry in-order holding buffer for words returned by the FIFO
module fifo_rd_skid
    import shared_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop;
    logic             do_push;

    // Entry 0 is always the oldest word; a pop shifts entry 1 down, a push fills the first free slot after the pop.
    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (do_pop) begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
        end
        if (do_push) begin
            if (count_d == 2'd0) begin
                ent0_d = push_data;
            end else begin
                ent1_d = push_data;
            end
            count_d = count_d + 2'd1;
        end
    end

    // Buffer storage and occupancy; reset clears contents so the output data reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign pop_data = ent0_q;
    assign count    = count_q;

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - credit-limited FIFO read engine feeding a valid/ready stream; FIFO_READER_STATS_EN adds counters
module fifo_reader #(
    parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  empty,
    input  logic                  underflow,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  err_underflow
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  uf_count
`endif
);

    import shared_pkg::*;

    rd_state_e state_q, state_d;
    logic      inflight_q, inflight_d;
    logic      err_q, err_d;
    logic [1:0] buf_count;
    logic [1:0] credit_used;
    logic      push;
    logic      pop;
    logic      uf_event;

    fifo_rd_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_out),
        .pop       (pop),
        .pop_data  (m_data),
        .count     (buf_count)
    );

    // Credit check: buffered words left after this cycle's pop plus the read landing now must leave room.
    always_comb begin
        m_valid     = (buf_count != 2'd0);
        pop         = m_valid && m_ready;
        push        = inflight_q && !underflow;
        uf_event    = inflight_q && underflow;
        credit_used = buf_count - {1'b0, pop} + {1'b0, inflight_q};
        rd_en       = (state_q == READ) && !empty && (credit_used < 2'd2);
        busy        = (state_q != IDLE) || (buf_count != 2'd0) || inflight_q;
    end

    // Next-state for the read FSM, the single in-flight read marker and the sticky error.
    always_comb begin
        state_d    = state_q;
        inflight_d = rd_en;
        err_d      = err_q || uf_event;
        case (state_q)
            IDLE:    if (enable) state_d = READ;
            READ:    if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_d = READ;
                end else if (!inflight_q && (buf_count == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and in-flight state; clearing inflight on reset drops any data still returning from old reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign err_underflow = err_q;

`ifdef FIFO_READER_STATS_EN
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0] uf_cnt_q, uf_cnt_d;

    // Delivered-word count wraps; underflow count saturates at all ones.
    always_comb begin
        rd_cnt_d = rd_cnt_q + CNT_WIDTH'(pop);
        uf_cnt_d = uf_cnt_q;
        if (uf_event && (uf_cnt_q != '1)) begin
            uf_cnt_d = uf_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            uf_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign uf_count = uf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed self-checking bench for fifo_reader
module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        rd_en;
    logic [15:0] data_out = 16'h0;
    logic        empty = 1'b1;
    logic        underflow = 1'b0;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        err_underflow;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] uf_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] fq[$];
    logic [15:0] rx[$];
    int          rx_cyc[$];
    int          cyc = 0;
    int          rd_pulses = 0;
    bit          rd_pend = 1'b0;
    bit          force_uf = 1'b0;

    fifo_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .rd_en         (rd_en),
        .data_out      (data_out),
        .empty         (empty),
        .underflow     (underflow),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .busy          (busy),
        .err_underflow (err_underflow)
`ifdef FIFO_READER_STATS_EN
        ,
        .rd_count      (rd_count),
        .uf_count      (uf_count)
`endif
    );

    always #5 clk = ~clk;

    // Monitor at the falling edge: reads issued, words transferred downstream.
    always @(negedge clk) begin
        cyc = cyc + 1;
        rd_pend = rd_en && !rst;
        if (!rst) begin
            if (rd_en) rd_pulses = rd_pulses + 1;
            if (m_valid && m_ready) begin
                rx.push_back(m_data);
                rx_cyc.push_back(cyc);
            end
        end
    end

    // FIFO model: a read in cycle N presents its word during cycle N+1.
    always @(posedge clk) begin
        #1;
        underflow = 1'b0;
        if (rd_pend) begin
            if (fq.size() > 0) data_out = fq.pop_front();
            else underflow = 1'b1;
            if (force_uf) begin
                underflow = 1'b1;
                force_uf  = 1'b0;
            end
        end
        rd_pend = 1'b0;
        empty = (fq.size() == 0);
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        force_uf = 1'b0;
        fq.delete();
        empty = 1'b1;
        @(posedge clk); #2;
        rx.delete();
        rx_cyc.delete();
        rd_pulses = 0;
        rst = 1'b0;
    endtask

    task automatic load(input int n, input logic [15:0] first);
        for (int i = 0; i < n; i++) fq.push_back(first + 16'(i));
        empty = (fq.size() == 0);
    endtask

    task automatic test_reset();
        #3;
        n_chk++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        n_chk++; if (m_valid !== 1'b0 || m_data !== 16'h0) begin n_fail++; $display("FAIL reset_out: valid %b data %h want 0/0000", m_valid, m_data); end
        n_chk++; if (busy !== 1'b0 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy %b err %b want 0/0", busy, err_underflow); end
`ifdef FIFO_READER_STATS_EN
        n_chk++; if (rd_count !== 16'd0 || uf_count !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: rd %0d uf %0d want 0/0", rd_count, uf_count); end
`endif
        fq.push_back(16'hA5A5);
        empty = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL first_cycle_rd_en: got %b want 0", rd_en); end
        @(negedge clk);
        n_chk++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL cycle1_rd_en: got %b want 1", rd_en); end
        @(negedge clk);
        n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL cycle2_valid: got %b want 0", m_valid); end
        @(negedge clk);
        n_chk++; if (m_valid !== 1'b1 || m_data !== 16'hA5A5) begin n_fail++; $display("FAIL cycle3_word: valid %b data %h want 1/a5a5", m_valid, m_data); end
    endtask

    task automatic test_stream();
        do_reset();
        load(8, 16'h0001);
        enable = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 20; k++) @(negedge clk);
        n_chk++; if (rx.size() != 8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", rx.size()); end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (i >= rx.size() || rx[i] !== 16'(i + 1)) begin
                n_fail++; $display("FAIL stream_order[%0d]: got %h want %h", i, (i < rx.size()) ? rx[i] : 16'hxxxx, 16'(i + 1));
            end
        end
        n_chk++; if (rx_cyc.size() != 8 || rx_cyc[7] - rx_cyc[0] != 7) begin n_fail++; $display("FAIL stream_bubbles: span %0d want 7", (rx_cyc.size() == 8) ? rx_cyc[7] - rx_cyc[0] : -1); end
`ifdef FIFO_READER_STATS_EN
        n_chk++; if (rd_count !== 16'd8) begin n_fail++; $display("FAIL stream_rd_count: got %0d want 8", rd_count); end
`endif
    endtask

    task automatic test_backpressure();
        int seen;
        int bad;
        seen = 0;
        bad = 0;
        do_reset();
        load(8, 16'h0001);
        enable = 1'b1;
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (m_valid) begin
                seen++;
                if (m_data !== 16'h0001) bad++;
            end
        end
        n_chk++; if (rd_pulses != 2) begin n_fail++; $display("FAIL bp_rd_pulses: got %0d want 2", rd_pulses); end
        n_chk++; if (seen != 2 || bad != 0) begin n_fail++; $display("FAIL bp_hold: valid cycles %0d unstable %0d want 2/0", seen, bad); end
        @(posedge clk); #2;
        m_ready = 1'b1;
        for (int k = 0; k < 30 && rx.size() < 8; k++) @(negedge clk);
        n_chk++; if (rx.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", rx.size()); end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (i >= rx.size() || rx[i] !== 16'(i + 1)) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, (i < rx.size()) ? rx[i] : 16'hxxxx, 16'(i + 1));
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        load(2, 16'h0011);
        fq[1] = 16'h0022;
        force_uf = 1'b1;
        enable = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) @(negedge clk);
        n_chk++; if (rx.size() != 1 || rx[0] !== 16'h0022) begin n_fail++; $display("FAIL uf_delivery: got %0d words first %h want 1/0022", rx.size(), (rx.size() > 0) ? rx[0] : 16'hxxxx); end
        n_chk++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_flag: got %b want 1", err_underflow); end
`ifdef FIFO_READER_STATS_EN
        n_chk++; if (uf_count !== 16'd1) begin n_fail++; $display("FAIL uf_count: got %0d want 1", uf_count); end
`endif
    endtask

    task automatic test_drain();
        do_reset();
        load(4, 16'h0001);
        enable = 1'b1;
        m_ready = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        enable = 1'b0;
        @(negedge clk);
        n_chk++; if (busy !== 1'b1 || m_valid !== 1'b1) begin n_fail++; $display("FAIL drain_busy: busy %b valid %b want 1/1", busy, m_valid); end
        @(posedge clk); #2;
        m_ready = 1'b1;
        for (int k = 0; k < 12 && busy; k++) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle: busy %b want 0", busy); end
        n_chk++; if (rx.size() != 2 || rx[0] !== 16'h0001 || rx[1] !== 16'h0002) begin n_fail++; $display("FAIL drain_words: got %0d words want 0001,0002", rx.size()); end
        n_chk++; if (rd_pulses != 2 || fq.size() != 2) begin n_fail++; $display("FAIL drain_no_reads: pulses %0d left %0d want 2/2", rd_pulses, fq.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load(4, 16'h0001);
        enable = 1'b1;
        m_ready = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 16'h0) begin n_fail++; $display("FAIL mid_reset_out: rd %b valid %b data %h want 0/0/0000", rd_en, m_valid, m_data); end
        n_chk++; if (busy !== 1'b0 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: busy %b err %b want 0/0", busy, err_underflow); end
`ifdef FIFO_READER_STATS_EN
        n_chk++; if (rd_count !== 16'd0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d want 0", rd_count); end
`endif
        enable = 1'b0;
        @(posedge clk); #2;
        rx.delete();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_chk++; if (rx.size() != 0 || m_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stale_return: words %0d valid %b busy %b want 0/0/0", rx.size(), m_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_underflow();
        test_drain();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
